// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-facing signal bundle for the hazard/stall controller.
// master = pipeline side driving hazard sources, slave = the controller.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             EX_MemRead;
  logic [4:0]       EX_rd;
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_use_rs;
  logic             ID_use_rt;
  logic             EX_branch_taken;
  logic             EX_md_start;
  logic             ID_md_use;
  logic             imem_ready;
  logic             PCWrite;
  logic             IF_IDWrite;
  logic             IF_Flush;
  logic             ID_EXFlush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output EX_MemRead, EX_rd, ID_rs, ID_rt, ID_use_rs, ID_use_rt,
           EX_branch_taken, EX_md_start, ID_md_use, imem_ready,
    input  PCWrite, IF_IDWrite, IF_Flush, ID_EXFlush, md_busy, stall_cycles
  );

  modport slave (
    input  EX_MemRead, EX_rd, ID_rs, ID_rt, ID_use_rs, ID_use_rt,
           EX_branch_taken, EX_md_start, ID_md_use, imem_ready,
    output PCWrite, IF_IDWrite, IF_Flush, ID_EXFlush, md_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central 5-stage pipeline hazard controller: redirect, mul/div and load-use
// stalls, fetch wait bubbles, plus a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 32
) (
  input logic             clk,
  input logic             reset,
  hazard_stall_ctrl_if.slave hz
);

  localparam int unsigned MD_CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} md_state_e;

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_q;
  logic                md_busy;
  logic                load_use;
  logic                pc_write, ifid_write, if_flush, idex_flush;

  // Mul/div occupancy state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start while BUSY is ignored so the window is never stretched
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hz.EX_md_start) begin
          state_d = BUSY;
          cnt_d   = MD_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - MD_CNT_W'(1);
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_busy  = (state_q == BUSY);
  assign load_use = hz.EX_MemRead && (hz.EX_rd != 5'd0) &&
                    ((hz.ID_use_rs && (hz.ID_rs == hz.EX_rd)) ||
                     (hz.ID_use_rt && (hz.ID_rt == hz.EX_rd)));

  // Same-cycle control, first matching rule wins
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    if_flush   = 1'b0;
    idex_flush = 1'b0;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      if_flush   = 1'b1;
      idex_flush = 1'b1;
    end else if (hz.EX_branch_taken) begin
      if_flush   = 1'b1;
      idex_flush = 1'b1;
    end else if ((md_busy && hz.ID_md_use) || load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (!hz.imem_ready) begin
      pc_write   = 1'b0;
      if_flush   = 1'b1;
    end
  end

  // Stall-cycle counter sticks at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_write && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign hz.PCWrite      = pc_write;
  assign hz.IF_IDWrite   = ifid_write;
  assign hz.IF_Flush     = if_flush;
  assign hz.ID_EXFlush   = idex_flush;
  assign hz.md_busy      = md_busy;
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed plus random bench for hazard_stall_ctrl against a cycle-indexed
// reference model of the priority rules, mul/div window and stall count.
module tb_hazard_stall_ctrl;

  localparam int unsigned MD_LAT  = 4;
  localparam int unsigned CW      = 6;
  localparam int          SAT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;

  hazard_stall_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_stall_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc;        // rising edges since reset release
  int md_s;       // cyc value during the accepted EX_md_start cycle
  int stall_cnt;  // unclamped count of PCWrite=0 cycles

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_busy();
    return ((cyc - md_s) >= 1) && ((cyc - md_s) <= int'(MD_LAT));
  endfunction

  // {PCWrite, IF_IDWrite, IF_Flush, ID_EXFlush} from the priority list
  function automatic logic [3:0] model_ctrl(input logic busy);
    logic lu;
    lu = hz.EX_MemRead && (hz.EX_rd != 5'd0) &&
         ((hz.ID_use_rs && hz.ID_rs == hz.EX_rd) || (hz.ID_use_rt && hz.ID_rt == hz.EX_rd));
    if (hz.EX_branch_taken)           return 4'b1111;
    if (busy && hz.ID_md_use)         return 4'b0001;
    if (lu)                           return 4'b0001;
    if (!hz.imem_ready)               return 4'b0110;
    return 4'b1100;
  endfunction

  task automatic model_reset();
    cyc       = 0;
    md_s      = -1000;
    stall_cnt = 0;
  endtask

  task automatic idle_inputs();
    hz.EX_MemRead      = 1'b0;
    hz.EX_rd           = 5'd0;
    hz.ID_rs           = 5'd0;
    hz.ID_rt           = 5'd0;
    hz.ID_use_rs       = 1'b0;
    hz.ID_use_rt       = 1'b0;
    hz.EX_branch_taken = 1'b0;
    hz.EX_md_start     = 1'b0;
    hz.ID_md_use       = 1'b0;
    hz.imem_ready      = 1'b1;
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic step(input string tag);
    logic [3:0] e;
    logic       busy;
    int         exp_cnt;
    #1;
    busy    = model_busy();
    e       = model_ctrl(busy);
    exp_cnt = (stall_cnt > SAT_MAX) ? SAT_MAX : stall_cnt;
    check({tag, ".PCWrite"},      32'(hz.PCWrite),      32'(e[3]));
    check({tag, ".IF_IDWrite"},   32'(hz.IF_IDWrite),   32'(e[2]));
    check({tag, ".IF_Flush"},     32'(hz.IF_Flush),     32'(e[1]));
    check({tag, ".ID_EXFlush"},   32'(hz.ID_EXFlush),   32'(e[0]));
    check({tag, ".md_busy"},      32'(hz.md_busy),      32'(busy));
    check({tag, ".stall_cycles"}, 32'(hz.stall_cycles), 32'(exp_cnt));
    assert (!(hz.EX_md_start && busy)) else $error("illegal EX_md_start while busy in %s", tag);
    @(posedge clk);
    if (!e[3]) stall_cnt++;
    if (hz.EX_md_start && !busy) md_s = cyc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".PCWrite"},      32'(hz.PCWrite),      32'd0);
    check({tag, ".IF_IDWrite"},   32'(hz.IF_IDWrite),   32'd0);
    check({tag, ".IF_Flush"},     32'(hz.IF_Flush),     32'd1);
    check({tag, ".ID_EXFlush"},   32'(hz.ID_EXFlush),   32'd1);
    check({tag, ".md_busy"},      32'(hz.md_busy),      32'd0);
    check({tag, ".stall_cycles"}, 32'(hz.stall_cycles), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b0;

    // Load-use on rs, then normal flow with one stall recorded
    hz.EX_MemRead = 1'b1; hz.EX_rd = 5'd5; hz.ID_rs = 5'd5; hz.ID_use_rs = 1'b1;
    step("load_use");
    idle_inputs();
    step("after_load_use");
    check("after_load_use.count_const", 32'(hz.stall_cycles), 32'd1);

    // r0 never hazards; an unused rt never hazards
    hz.EX_MemRead = 1'b1; hz.EX_rd = 5'd0; hz.ID_rs = 5'd0; hz.ID_use_rs = 1'b1;
    step("rd_zero");
    idle_inputs();
    hz.EX_MemRead = 1'b1; hz.EX_rd = 5'd7; hz.ID_rt = 5'd7; hz.ID_use_rt = 1'b0;
    step("rt_unused");
    hz.ID_use_rt = 1'b1;
    step("rt_used");

    // Branch beats load-use and fetch wait
    hz.EX_branch_taken = 1'b1; hz.imem_ready = 1'b0;
    step("branch_over");
    idle_inputs();

    // Mul/div window with a dependent instruction waiting in ID
    hz.EX_md_start = 1'b1;
    step("md_start");
    hz.EX_md_start = 1'b0; hz.ID_md_use = 1'b1;
    for (int i = 0; i < int'(MD_LAT); i++) step("md_stall");
    step("md_release");
    check("md_release.PCWrite_const", 32'(hz.PCWrite), 32'd1);
    idle_inputs();

    // Window with no dependent instruction: no stall
    hz.EX_md_start = 1'b1;
    step("md_start2");
    hz.EX_md_start = 1'b0;
    for (int i = 0; i < int'(MD_LAT) + 1; i++) step("md_nodep");

    // Fetch wait for three cycles
    hz.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("fetch_wait");
    hz.imem_ready = 1'b1;
    step("fetch_done");

    // Asynchronous reset two cycles into BUSY
    hz.EX_md_start = 1'b1;
    step("md_start3");
    hz.EX_md_start = 1'b0;
    step("busy1");
    step("busy2");
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    do_reset();
    hz.EX_md_start = 1'b1;
    step("md_restart");
    hz.EX_md_start = 1'b0; hz.ID_md_use = 1'b1;
    for (int i = 0; i < int'(MD_LAT) + 2; i++) step("md_restart_win");
    idle_inputs();

    // Random traffic with a narrow register space so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      hz.EX_MemRead      = ($urandom_range(0, 1) == 1);
      hz.EX_rd           = 5'($urandom_range(0, 3));
      hz.ID_rs           = 5'($urandom_range(0, 3));
      hz.ID_rt           = 5'($urandom_range(0, 3));
      hz.ID_use_rs       = ($urandom_range(0, 1) == 1);
      hz.ID_use_rt       = ($urandom_range(0, 1) == 1);
      hz.EX_branch_taken = ($urandom_range(0, 7) == 0);
      hz.ID_md_use       = ($urandom_range(0, 2) == 0);
      hz.imem_ready      = ($urandom_range(0, 3) != 0);
      hz.EX_md_start     = !model_busy() && !hz.EX_branch_taken && ($urandom_range(0, 5) == 0);
      step("random");
    end
    idle_inputs();

    // Counter saturation at all-ones
    do_reset();
    hz.imem_ready = 1'b0;
    for (int i = 0; i < SAT_MAX + 8; i++) step("saturate");
    hz.imem_ready = 1'b1;
    step("saturated");
    check("saturated.count_const", 32'(hz.stall_cycles), 32'(SAT_MAX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central hazard controller for the 5-stage pipeline. It drives PC write-enable, IF/ID write-enable and flush, and the ID/EX bubble. It resolves load-use hazards, EX-stage taken branches, instruction-memory wait states and multi-cycle mul/div occupancy. It also keeps a saturating stall-cycle performance counter.

Parameters:
MD_LATENCY, 32, cycles the mul/div unit is busy after EX_md_start (legal range 2..255)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
EX_MemRead  in  1  EX-stage instruction is a load
EX_rd  in  5  EX-stage destination register
ID_rs  in  5  ID-stage source register rs
ID_rt  in  5  ID-stage source register rt
ID_use_rs  in  1  ID instruction reads rs
ID_use_rt  in  1  ID instruction reads rt
EX_branch_taken  in  1  EX-stage branch/jump resolved taken (PC redirect this cycle)
EX_md_start  in  1  EX-stage mul/div issues to the mul/div unit this cycle
ID_md_use  in  1  ID instruction is mul/div or reads HI/LO
imem_ready  in  1  instruction memory returns valid IF_inst this cycle
PCWrite  out  1  PC register write enable
IF_IDWrite  out  1  IF/ID register write enable
IF_Flush  out  1  IF/ID register loads bubble (nop)
ID_EXFlush  out  1  ID/EX register loads bubble
md_busy  out  1  mul/div unit occupied
stall_cycles  out  CNT_W  count of cycles with PCWrite=0

Behaviour:
- Clock and reset: single clock domain, rising edge. Reset is asynchronous and active-high.
- Outputs while reset=1 (all outputs are combinational from state and inputs):
  - PCWrite=0, IF_IDWrite=0, IF_Flush=1, ID_EXFlush=1.
  - md_busy=0, stall_cycles=0, mul/div FSM in IDLE, counter 0.
- Control outputs use zero latency, same cycle. Evaluate in strict priority order; the first match wins:
  1. Redirect (EX_branch_taken=1):
     - PCWrite=1, IF_IDWrite=1, IF_Flush=1, ID_EXFlush=1.
     - Kills both younger instructions.
     - Overrides every hazard below, including imem_ready=0.
  2. MD hazard (md_busy=1 && ID_md_use=1):
     - PCWrite=0, IF_IDWrite=0, IF_Flush=0, ID_EXFlush=1.
     - Holds IF/ID and inserts a bubble into ID/EX.
  3. Load-use:
     - Condition: EX_MemRead=1 && EX_rd!=0 && ((ID_use_rs && ID_rs==EX_rd) || (ID_use_rt && ID_rt==EX_rd)).
     - Response: same outputs as item 2.
  4. Fetch wait (imem_ready=0):
     - PCWrite=0, IF_IDWrite=1, IF_Flush=1, ID_EXFlush=0.
     - Bubble enters ID; older stages keep advancing.
  5. Otherwise: PCWrite=1, IF_IDWrite=1, IF_Flush=0, ID_EXFlush=0.
- Mul/div FSM states: IDLE, BUSY. Counter md_cnt is clog2(MD_LATENCY) bits wide.
  - IDLE, EX_md_start=1: go to BUSY, md_cnt <= MD_LATENCY-1.
  - BUSY, md_cnt!=0: md_cnt decrements.
  - BUSY, md_cnt==0: go to IDLE.
  - md_busy = (state==BUSY). The unit is busy for exactly MD_LATENCY cycles, starting the cycle after EX_md_start.
  - EX_md_start while BUSY is illegal; it is ignored and the counter is not reloaded. The bench asserts it never occurs.
  - EX_branch_taken does not abort BUSY, because the mul/div instruction is older than the branch's victims.
  - EX_branch_taken and EX_md_start never coincide (same EX instruction). Behaviour is unspecified if they do.
- stall_cycles:
  - Increments on each rising edge where reset=0 and PCWrite=0.
  - Saturates at all-ones and does not wrap.
- Reset mid-BUSY: md_busy drops immediately (asynchronous). FSM goes to IDLE; the counter clears.

Test Plan:
- Load-use: EX_MemRead=1, EX_rd=5, ID_rs=5, ID_use_rs=1 -> PCWrite=0, IF_IDWrite=0, ID_EXFlush=1 for that cycle. The next cycle, with EX_MemRead=0, gives normal flow and stall_cycles=1.
- Register 0 and unused source: EX_rd=0 matching ID_rs=0, then EX_rd=7 matching ID_rt=7 with ID_use_rt=0 -> no stall either time; PCWrite=1.
- Branch over hazard: EX_branch_taken=1 together with a load-use match and imem_ready=0 -> PCWrite=1, IF_IDWrite=1, IF_Flush=1, ID_EXFlush=1.
- Mul/div, MD_LATENCY=4: pulse EX_md_start, then hold ID_md_use=1 -> md_busy=1 for exactly 4 cycles. The stall lasts exactly 4 cycles, then PCWrite=1. With ID_md_use=0, no stall occurs during BUSY.
- Fetch wait: hold imem_ready=0 for 3 cycles -> PCWrite=0, IF_Flush=1, IF_IDWrite=1, ID_EXFlush=0 on each of the 3 cycles; stall_cycles increases by 3.
- Reset mid-BUSY: assert reset asynchronously 2 cycles into BUSY -> md_busy=0, stall_cycles=0 and flush outputs=1 immediately. After release, EX_md_start restarts a full MD_LATENCY window.
